booth_mult: RTL and testbench
=============================

# booth_mult

Sequential radix-2 Booth multiplier for signed two's-complement operands; the circuit under test of the BIST tester. It takes the 8-bit LFSR pattern as {multiplicand, multiplier}, starts on `start` (driven by the tester's `start_test`), and holds `busy` high while it iterates. The tester's MISR captures the 2N-bit product once `busy` falls.

## Interface
- `N`, 4: operand width in bits; product is 2N bits.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; accepted only in IDLE.
- `mcand`  in  N  signed multiplicand (tester drives `pattern[7:4]`).
- `mplier`  in  N  signed multiplier (tester drives `pattern[3:0]`).
- `busy`  out  1  high from the accept edge until the result is loaded.
- `done`  out  1  one-cycle pulse, coincident with the cycle `prod` first holds the new result.
- `prod`  out  2N  signed product; registered; holds its value until the next completion.

## Operation
- Reset values: state IDLE, `busy`=0, `done`=0, `prod`=0, and all internal registers 0.
- Internal registers:
  - A: N+1 bits, accumulator with a guard bit so that −2^(N−1) × −2^(N−1) is correct.
  - Q: N bits.
  - Q₋₁: 1 bit.
  - M: N+1 bits, sign-extended multiplicand.
  - cnt: ⌈log2(N+1)⌉ bits.
- States:
  - IDLE: if `start`=1, load A=0, Q=`mplier`, Q₋₁=0, M=sext(`mcand`), cnt=N; go to RUN.
  - RUN: one Booth step per cycle, using {Q[0],Q₋₁}:
    - 01: A=A+M.
    - 10: A=A−M.
    - 00 or 11: no add.
    - Then arithmetic shift right of {A,Q,Q₋₁} by 1 and cnt=cnt−1.
    - After the step that takes cnt 1→0, go to FINISH.
  - FINISH: `prod`={A,Q}[2N−1:0]; go to IDLE.
- Operands are sampled only on the accept edge. Changes on `mcand`/`mplier` during RUN/FINISH have no effect.
- `start` in RUN or FINISH is ignored, not queued.
- All arithmetic is mod 2^(N+1) on A. The product always fits in 2N signed bits; the guard bit is discarded.
- Reset asserted mid-operation: immediate return to IDLE with all outputs at reset values. The partial result is lost and `prod` reads 0.

## Timing
- Accept at edge k (IDLE, `start`=1): `busy`=1 after edge k.
- Booth steps occur on edges k+1 … k+N.
- Edge k+N+1: `prod` is loaded, `busy`=0, and `done`=1 for exactly one cycle.
- `busy` is high for exactly N+1 cycles (5 for N=4).
- Latency from `start` to valid `prod` is N+1 edges after acceptance.
- Earliest next accept is edge k+N+2. With `start` held high continuously, a new operation begins every N+2 cycles.
- `busy` and `done` are driven directly from registers, so there is no combinational path from `start` to any output.

## Structure
- Package `booth_pkg`:
  - state enum {IDLE, RUN, FINISH}.
  - default constant `BOOTH_N`=4.
  - localparam for the cnt width.
- Sub-module `booth_ctrl`:
  - Contents: FSM, cnt, and the `busy`/`done` registers.
  - Outputs: `load`, `step`, `finish` strobes.
  - The top level holds the A/Q/M datapath and the `prod` register.

## Test plan
- Reset, then 3×5: `busy` high 5 cycles → `prod`=0x0F with `done` pulse on edge k+5.
- −8×−8 (mcand=0x8, mplier=0x8) → `prod`=0x40 (guard-bit case).
- −3×7 (0xD, 0x7) → `prod`=0xEB. Then 7×0 → `prod`=0x00, and `prod` holds 0xEB until that second completion.
- `start` pulsed again on cycles k+2 and k+5 and operands changed mid-run → result unchanged, no extra `busy` period; `start` held high → accepts at k and k+6.
- `reset` asserted at cycle k+3 → `busy`=0, `prod`=0 immediately; a subsequent 2×−1 → `prod`=0xFE.
- Exhaustive 256 operand pairs compared against a signed reference model; the feed follows the tester's handshake order.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam int BOOTH_N = 4;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int CNT_W = cnt_width(BOOTH_N);

endpackage

// File: rtl/booth_ctrl.sv
// Sequencer for the Booth multiplier: FSM, step counter and busy/done flags.
module booth_ctrl
    import booth_pkg::*;
#(
    parameter int N  = BOOTH_N,
    parameter int CW = cnt_width(N)
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic load,
    output logic step,
    output logic finish,
    output logic busy,
    output logic done
);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == CW'(1)) begin
                    state_nxt = FINISH;
                end
            end
            FINISH: begin
                finish    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // busy/done are registered from next-state so no start->output path exists
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
            done  <= finish;
            if (load) begin
                cnt <= CW'(N);
            end else if (step) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

endmodule

// File: rtl/booth_mult.sv
// Radix-2 Booth multiplier datapath (A/Q/Q-1/M) and product register.
module booth_mult
    import booth_pkg::*;
#(
    parameter int N = BOOTH_N
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N-1:0]   mcand,
    input  logic [N-1:0]   mplier,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] prod
);

    logic         load;
    logic         step;
    logic         finish;
    logic [N:0]   acc;
    logic [N:0]   mreg;
    logic [N:0]   sum;
    logic [N-1:0] qreg;
    logic         qm1;

    booth_ctrl #(.N(N)) u_ctrl (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .load   (load),
        .step   (step),
        .finish (finish),
        .busy   (busy),
        .done   (done)
    );

    // guard bit in acc keeps -2^(N-1) * -2^(N-1) from overflowing
    always_comb begin
        sum = acc;
        unique case ({qreg[0], qm1})
            2'b01:   sum = acc + mreg;
            2'b10:   sum = acc - mreg;
            default: sum = acc;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc  <= '0;
            mreg <= '0;
            qreg <= '0;
            qm1  <= 1'b0;
        end else if (load) begin
            acc  <= '0;
            mreg <= {mcand[N-1], mcand};
            qreg <= mplier;
            qm1  <= 1'b0;
        end else if (step) begin
            acc  <= {sum[N], sum[N:1]};
            qreg <= {sum[0], qreg[N-1:1]};
            qm1  <= qreg[0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod <= '0;
        end else if (finish) begin
            prod <= {acc[N-1:0], qreg};
        end
    end

endmodule

// File: tb/tb_booth_mult.sv
// Directed + random check of booth_mult against a signed-arithmetic model.
module tb_booth_mult;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] mcand;
    logic [3:0] mplier;
    logic       busy;
    logic       done;
    logic [7:0] prod;

    int checks;
    int failures;

    booth_mult #(.N(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .mcand  (mcand),
        .mplier (mplier),
        .busy   (busy),
        .done   (done),
        .prod   (prod)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
        int sa;
        int sb;
        sa = $signed(a);
        sb = $signed(b);
        return 8'(sa * sb);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input string tag);
        int bcnt;
        mcand  = a;
        mplier = b;
        start  = 1'b1;
        tick();
        start = 1'b0;
        bcnt  = 0;
        while (busy && bcnt < 20) begin
            bcnt++;
            tick();
        end
        chk({tag, "_busy_len"}, 32'(bcnt), 32'd5);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_prod"}, 32'(prod), 32'(ref_mul(a, b)));
    endtask

    initial begin
        logic [3:0] ra;
        logic [3:0] rb;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        start    = 1'b0;
        mcand    = '0;
        mplier   = '0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_prod", 32'(prod), 32'd0);
        reset = 1'b0;
        tick();

        // 3 x 5 with cycle-exact timing
        mcand  = 4'd3;
        mplier = 4'd5;
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t35_busy_%0d", i), 32'(busy), 32'd1);
            chk($sformatf("t35_done_%0d", i), 32'(done), 32'd0);
            tick();
        end
        chk("t35_busy_end", 32'(busy), 32'd0);
        chk("t35_done_end", 32'(done), 32'd1);
        chk("t35_prod", 32'(prod), 32'h0F);
        tick();
        chk("t35_done_pulse", 32'(done), 32'd0);
        chk("t35_prod_hold", 32'(prod), 32'h0F);

        do_op(4'h8, 4'h8, "m8m8");
        chk("m8m8_val", 32'(prod), 32'h40);
        do_op(4'hD, 4'h7, "m3x7");
        chk("m3x7_val", 32'(prod), 32'hEB);

        // 7 x 0: prod must hold old value while busy
        mcand  = 4'h7;
        mplier = 4'h0;
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("hold_prod_%0d", i), 32'(prod), 32'hEB);
            tick();
        end
        chk("z_done", 32'(done), 32'd1);
        chk("z_prod", 32'(prod), 32'h00);
        tick();

        // start re-pulsed mid-run and operands changed
        mcand  = 4'h5;
        mplier = 4'hE;
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start  = 1'b1;
        mcand  = 4'h7;
        mplier = 4'h7;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ign_done", 32'(done), 32'd1);
        chk("ign_busy", 32'(busy), 32'd0);
        chk("ign_prod", 32'(prod), 32'hF6);
        tick();
        chk("ign_no_rebusy", 32'(busy), 32'd0);
        chk("ign_done_low", 32'(done), 32'd0);

        // start held high: accepts at k and k+6
        mcand  = 4'h2;
        mplier = 4'h3;
        start  = 1'b1;
        tick();
        chk("held_busy_k", 32'(busy), 32'd1);
        mcand  = 4'h1;
        mplier = 4'hF;
        for (int i = 0; i < 4; i++) tick();
        tick();
        chk("held_done1", 32'(done), 32'd1);
        chk("held_busy_gap", 32'(busy), 32'd0);
        chk("held_prod1", 32'(prod), 32'h06);
        tick();
        chk("held_busy_k6", 32'(busy), 32'd1);
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("held_done2", 32'(done), 32'd1);
        chk("held_prod2", 32'(prod), 32'hFF);
        tick();

        // reset mid-operation
        mcand  = 4'h6;
        mplier = 4'h3;
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_prod", 32'(prod), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_idle", 32'(busy), 32'd0);
        do_op(4'h2, 4'hF, "p2m1");
        chk("p2m1_val", 32'(prod), 32'hFE);

        // exhaustive, tester handshake order
        for (int p = 0; p < 256; p++) begin
            ra = 4'(p >> 4);
            rb = 4'(p);
            do_op(ra, rb, $sformatf("ex_%02h", p));
            tick();
        end

        // random operands with random idle gaps
        for (int r = 0; r < 40; r++) begin
            ra = 4'($urandom);
            rb = 4'($urandom);
            do_op(ra, rb, $sformatf("rnd_%0d", r));
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
